pipelined_addsub: RTL and testbench



---
 rtl/pipelined_addsub.sv | 148 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES equal chunks,
// one chunk adder per clock, with the chunk carry registered between stages
// and the still-pending upper operand chunks skewed down the pipe.
// Optional flags (signed overflow, zero) are built only when the macro
// PIPE_ADDSUB_FLAGS_EN is defined; otherwise ovf and zero are tied to 0.
// WIDTH must be divisible by STAGES (1..8).
//
// Handshake: a beat moves on a rising edge when valid && ready. in_ready
// equals the global advance (!out_valid || out_ready) and never looks at
// in_valid. out_valid/sum/cout/flags hold steady while out_valid && !out_ready,
// and every stage register holds with them. The pipe has no bubble squeezing.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  // Subtraction is A + ~B + 1; cin is ignored in that case.
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits arriving at this stage: chunk k plus everything above it.
    localparam int NW = (STAGES - k) * CW;

    logic [NW-1:0]         na;
    logic [NW-1:0]         nb;
    logic                  ci;
    logic                  vin;
    logic [CW:0]           add;
    logic                  v;
    logic                  c;
    logic [(k+1)*CW-1:0]   s;
`ifdef PIPE_ADDSUB_FLAGS_EN
    logic                  zin;
    logic                  z;
`endif

    assign add = {1'b0, na[CW-1:0]} + {1'b0, nb[CW-1:0]} + {{CW{1'b0}}, ci};

    if (k == 0) begin : g_src
      assign na  = a;
      assign nb  = b_eff;
      assign ci  = c0;
      assign vin = in_valid;
`ifdef PIPE_ADDSUB_FLAGS_EN
      assign zin = 1'b1;
`endif
      // First chunk of the result.
      always_ff @(posedge clk) begin
        if (rst)      s <= '0;
        else if (adv) s <= add[CW-1:0];
      end
    end else begin : g_src
      assign na  = stg[k-1].g_pend.pa;
      assign nb  = stg[k-1].g_pend.pb;
      assign ci  = stg[k-1].c;
      assign vin = stg[k-1].v;
`ifdef PIPE_ADDSUB_FLAGS_EN
      assign zin = stg[k-1].z;
`endif
      // Append this chunk above the lower chunks passed down unchanged.
      always_ff @(posedge clk) begin
        if (rst)      s <= '0;
        else if (adv) s <= {add[CW-1:0], stg[k-1].s};
      end
    end

    // Stage valid bit and the 1-bit carry into the next chunk.
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        c <= 1'b0;
      end else if (adv) begin
        v <= vin;
        c <= add[CW];
      end
    end

    if (k < STAGES - 1) begin : g_pend
      // Pending upper chunks of A and B'; their top bits are the operand signs.
      logic [NW-CW-1:0] pa;
      logic [NW-CW-1:0] pb;

      // Skew the unused operand chunks one stage further down.
      always_ff @(posedge clk) begin
        if (adv) begin
          pa <= na[NW-1:CW];
          pb <= nb[NW-1:CW];
        end
      end
    end

`ifdef PIPE_ADDSUB_FLAGS_EN
    // Running zero flag: this chunk is zero and every lower chunk was zero.
    always_ff @(posedge clk) begin
      if (rst)      z <= 1'b0;
      else if (adv) z <= zin && (add[CW-1:0] == '0);
    end
`endif
  end

  assign out_valid = stg[STAGES-1].v;
  assign sum       = stg[STAGES-1].s;
  assign cout      = stg[STAGES-1].c;

`ifdef PIPE_ADDSUB_FLAGS_EN
  logic ovf_q;

  // Signed overflow: operand signs agree and the result sign differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= (stg[STAGES-1].na[CW-1] == stg[STAGES-1].nb[CW-1]) &&
               (stg[STAGES-1].add[CW-1] != stg[STAGES-1].na[CW-1]);
    end
  end

  assign ovf  = ovf_q;
  assign zero = stg[STAGES-1].z;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub: directed cases with literal expectations,
// latency checks at STAGES=1/2/4, a stall/backpressure case, reset flush, and a
// randomized stream checked against a plain-arithmetic model via an expected
// queue. Flag expectations follow PIPE_ADDSUB_FLAGS_EN.
module tb_pipelined_addsub;
  localparam int W  = 64;
  localparam int WE = W + 3;  // {cout, ovf, zero, sum}
`ifdef PIPE_ADDSUB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  logic         in_valid_x;
  logic         in_ready4, in_ready1;
  logic         out_valid4, out_valid1;
  logic [W-1:0] sum4, sum1;
  logic         cout4, cout1, ovf4, ovf1, zero4, zero1;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid4), .out_ready(1'b1),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  pipelined_addsub #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(1'b1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [WE-1:0] exp_q[$];
  logic [W-1:0]  got_q[$];
  logic [WE-1:0] exp_v;
  logic          held_v = 1'b0;
  logic [WE:0]   held;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic on the whole operands.
  function automatic logic [WE-1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                          input logic tc, input logic ts);
    logic [W:0]          u;
    logic [W-1:0]        s;
    logic                co, ov, z;
    logic signed [W+1:0] sa_x, sb_x, sres, lim;
    sa_x = $signed({{2{ta[W-1]}}, ta});
    sb_x = $signed({{2{tb[W-1]}}, tb});
    if (ts) begin
      s    = ta - tb;
      co   = (ta >= tb);
      sres = sa_x - sb_x;
    end else begin
      u    = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      s    = u[W-1:0];
      co   = u[W];
      sres = sa_x + sb_x + $signed({{(W+1){1'b0}}, tc});
    end
    lim = 1;
    lim = lim <<< (W - 1);
    ov  = FL && ((sres >= lim) || (sres < -lim));
    z   = FL && (s == '0);
    return {co, ov, z, s};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return {{(W/2){1'b0}}, {(W/2){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) check("stall_hold", {out_valid, cout, ovf, zero, sum}, held);
      held_v = out_valid && !out_ready;
      held   = {out_valid, cout, ovf, zero, sum};
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got sum 0x%0h, required no output", sum);
        end else begin
          exp_v = exp_q.pop_front();
          check("sum",  sum,  exp_v[W-1:0]);
          check("cout", cout, exp_v[W+2]);
          check("ovf",  ovf,  exp_v[W+1]);
          check("zero", zero, exp_v[W]);
          got_q.push_back(sum);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with an empty pipe and out_ready=1.
  task automatic run_beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, output int lat, output logic [WE-1:0] res);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {cout, ovf, zero, sum};
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int cyc;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int            lat, lat4, lat1, i, stall, cyc, sent;
    logic          first, fired, probe;
    logic [WE-1:0] res;
    logic [W-1:0]  s4, s1;

    rst = 1'b1; in_valid = 1'b0; in_valid_x = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Model pins.
    check("model_sub", model(64'd5, 64'd7, 1'b1, 1'b1), {3'b000, 64'hFFFF_FFFF_FFFF_FFFE});
    check("model_ovf", model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0),
          {1'b0, FL, 1'b0, 64'h8000_0000_0000_0000});

    // 1: cross-chunk carry, latency 2.
    run_beat(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, res);
    check("t1_lat", lat, 2);
    check("t1_sum", res[W-1:0], 64'h0000_0001_0000_0000);
    check("t1_cout", res[W+2], 0);
    // 2: wrap to zero.
    run_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, res);
    check("t2_sum", res[W-1:0], 64'd0);
    check("t2_cout", res[W+2], 1);
    check("t2_zero", res[W], FL);
    check("t2_ovf", res[W+1], 0);
    // 3: subtract with borrow, cin ignored.
    run_beat(64'd5, 64'd7, 1'b1, 1'b1, lat, res);
    check("t3_sum", res[W-1:0], 64'hFFFF_FFFF_FFFF_FFFE);
    check("t3_cout", res[W+2], 0);
    // 4: signed overflow.
    run_beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, res);
    check("t4_sum", res[W-1:0], 64'h8000_0000_0000_0000);
    check("t4_ovf", res[W+1], FL);
    check("t4_zero", res[W], 0);

    // Latency at STAGES=4 and STAGES=1.
    a = 64'h0000_0000_FFFF_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid_x = 1'b1;
    @(posedge clk); #1;
    in_valid_x = 1'b0;
    lat4 = 0; lat1 = 0; s4 = '0; s1 = '0;
    for (int e = 1; e <= 10; e++) begin
      if (out_valid4 && lat4 == 0) begin lat4 = e; s4 = sum4; end
      if (out_valid1 && lat1 == 0) begin lat1 = e; s1 = sum1; end
      @(posedge clk); #1;
    end
    check("lat_s4", lat4, 4);
    check("lat_s1", lat1, 1);
    check("sum_s4", s4, 64'h0000_0001_0000_0000);
    check("sum_s1", s1, 64'h0000_0001_0000_0000);

    // 5: four back-to-back beats, 3-cycle stall after the first result.
    drain();
    got_q.delete();
    first = 1'b0; stall = 0; i = 0; fired = 1'b0; cyc = 0;
    while ((i < 4 || got_q.size() < 4) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (fired) begin i++; in_valid = 1'b0; end
      probe = 1'b0;
      if (out_valid && !first) begin first = 1'b1; stall = 3; probe = 1'b1; end
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      if (!in_valid && i < 4) begin
        a = W'(i); b = W'(i + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      #1;
      if (probe) check("t5_in_ready_drop", in_ready, 0);
      fired = in_valid && in_ready;
    end
    check("t5_count", got_q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < got_q.size()) check("t5_order", got_q[j], 64'(2 * j + 1));
    end
    drain();

    // 6: reset with two beats in flight.
    out_ready = 1'b0; a = 64'd3; b = 64'd4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 64'd10; b = 64'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t6_inflight", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_sum", sum, 0);
    check("t6_cout", cout, 0);
    check("t6_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("t6_no_stale", out_valid, 0);
    end

    // Randomized stream with random backpressure.
    sent = 0; cyc = 0; fired = 1'b0;
    while (sent < 400 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (fired) begin sent++; in_valid = 1'b0; end
      out_ready = ($urandom_range(0, 99) < 70);
      if (!in_valid && sent < 400 && $urandom_range(0, 99) < 75) begin
        a = rand_op(); b = rand_op(); cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      end
      #1;
      fired = in_valid && in_ready;
    end
    check("stream_sent", sent, 400);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
